// File: rtl/ma_pkg.sv
// Constants and helpers shared by the multiply-accumulate stage and its result FIFO.
package ma_pkg;

   localparam int MA_DATA_W = 5;
   localparam int MA_SUM_W  = 8;

   // Add at one extra bit, then clamp to all-ones instead of wrapping.
   function automatic logic [MA_SUM_W-1:0] sat_add(input logic [MA_SUM_W-1:0]  sum,
                                                   input logic [MA_DATA_W-1:0] data);
      logic [MA_SUM_W:0] total;
      total = {1'b0, sum} + {{(MA_SUM_W + 1 - MA_DATA_W){1'b0}}, data};
      return total[MA_SUM_W] ? {MA_SUM_W{1'b1}} : total[MA_SUM_W-1:0];
   endfunction

endpackage

// File: rtl/ma_fifo_mem.sv
// Storage array for the result FIFO: one write port, one combinational read port.
module ma_fifo_mem #(
   parameter int DATA_W = 5,
   parameter int DEPTH  = 4,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately not reset; the read side masks stale data.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ma_result_fifo.sv
// Result FIFO behind the multiply-accumulate stage, with a saturating running
// total and a sticky overflow flag.
module ma_result_fifo
   import ma_pkg::*;
#(
   parameter int DATA_W = MA_DATA_W,
   parameter int DEPTH  = 4,
   parameter int SUM_W  = MA_SUM_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       out_ready,
   input  logic                       clr,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [SUM_W-1:0]           sum
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count_q;
   logic [DATA_W-1:0] rd_word;
   logic              wr;
   logic              rd;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;

   // Handshake: a word moves on any edge where valid and ready are both high.
   // in_ready depends only on full and out_valid only on empty, so neither side
   // ever sees a combinational path from the other; a full FIFO refuses a write
   // even while it is being read.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign wr        = in_valid & in_ready;
   assign rd        = out_valid & out_ready;

   assign out_data  = empty ? '0 : rd_word;

   ma_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         case ({wr, rd})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // clr takes priority over a same-cycle overflow event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         sum      <= '0;
      end else if (clr) begin
         overflow <= 1'b0;
         sum      <= wr ? {{(SUM_W - DATA_W){1'b0}}, in_data} : '0;
      end else begin
         if (in_valid && full) overflow <= 1'b1;
         if (wr)               sum      <= sat_add(sum, in_data);
      end
   end

endmodule

// File: tb/tb_ma_result_fifo.sv
// Bench for ma_result_fifo: scenario tasks plus a scoreboard on the read side.
module tb_ma_result_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [4:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [4:0] out_data;
   logic       out_ready;
   logic       clr;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
   logic [7:0] sum;

   int n_cmp = 0;
   int n_err = 0;

   logic [4:0] exp_q[$];
   int         m_count = 0;
   int         m_sum   = 0;
   logic       m_ovf   = 1'b0;

   ma_result_fifo dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .clr       (clr),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .sum       (sum)
   );

   always #5 clk = ~clk;

   // Scoreboard: a read happens at the coming posedge, so check the head now.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got out_data %0d, want no word", out_data);
         end else begin
            logic [4:0] exp_w;
            exp_w = exp_q.pop_front();
            if (out_data !== exp_w) begin
               n_err++;
               $display("FAIL sb_data: got %0d want %0d", out_data, exp_w);
            end
         end
      end
   end

   // Drive one cycle and advance the reference model; returns #1 after the edge.
   task automatic cycle(input logic v, input logic [4:0] d, input logic r, input logic c);
      bit m_wr;
      bit m_rd;
      int t;
      in_valid = v; in_data = d; out_ready = r; clr = c;
      m_wr = v && (m_count != 4);
      m_rd = r && (m_count != 0);
      if (v && m_count == 4) m_ovf = 1'b1;
      if (c) begin
         m_ovf = 1'b0;
         m_sum = m_wr ? int'(d) : 0;
      end else if (m_wr) begin
         t = m_sum + int'(d);
         m_sum = (t > 255) ? 255 : t;
      end
      if (m_wr) exp_q.push_back(d);
      m_count = m_count + int'(m_wr) - int'(m_rd);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_count = 0; m_sum = 0; m_ovf = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_data = 5'd7; out_ready = 1'b0; clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (count !== 3'd0)   begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
      n_cmp++; if (empty !== 1'b1)   begin n_err++; $display("FAIL rst_empty: got %b want 1", empty); end
      n_cmp++; if (full !== 1'b0)    begin n_err++; $display("FAIL rst_full: got %b want 0", full); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 5'd0) begin n_err++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
      n_cmp++; if (sum !== 8'd0)     begin n_err++; $display("FAIL rst_sum: got %0d want 0", sum); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      model_reset();
      cycle(1'b1, 5'd7, 1'b0, 1'b0);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_first_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 5'd7) begin n_err++; $display("FAIL rst_first_data: got %0d want 7", out_data); end
      cycle(1'b0, 5'd0, 1'b1, 1'b0);
      cycle(1'b0, 5'd0, 1'b0, 1'b1);
      n_cmp++; if (sum !== 8'd0) begin n_err++; $display("FAIL rst_clr_sum: got %0d want 0", sum); end
   endtask

   task automatic test_ordering();
      logic [4:0] words [4];
      words = '{5'd1, 5'd6, 5'd9, 5'd25};
      for (int i = 0; i < 4; i++) cycle(1'b1, words[i], 1'b0, 1'b0);
      n_cmp++; if (full !== 1'b1)     begin n_err++; $display("FAIL ord_full: got %b want 1", full); end
      n_cmp++; if (count !== 3'd4)    begin n_err++; $display("FAIL ord_count: got %0d want 4", count); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ord_in_ready: got %b want 0", in_ready); end
      for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 1'b1, 1'b0);
      n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL ord_empty: got %b want 1", empty); end
      n_cmp++; if (sum !== 8'd41)     begin n_err++; $display("FAIL ord_sum: got %0d want 41", sum); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ord_drained: got %0d words left want 0", exp_q.size()); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 1'b0, 1'b0);
      cycle(1'b1, 5'd31, 1'b0, 1'b0);
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
      n_cmp++; if (count !== 3'd4)    begin n_err++; $display("FAIL ovf_count: got %0d want 4", count); end
      n_cmp++; if (sum !== 8'd51)     begin n_err++; $display("FAIL ovf_sum: got %0d want 51", sum); end
      cycle(1'b0, 5'd0, 1'b0, 1'b1);
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", overflow); end
      n_cmp++; if (sum !== 8'd0)      begin n_err++; $display("FAIL ovf_clr_sum: got %0d want 0", sum); end
      n_cmp++; if (count !== 3'd4)    begin n_err++; $display("FAIL ovf_clr_count: got %0d want 4", count); end
      // clr in the same cycle as an overflow event leaves the flag clear
      cycle(1'b1, 5'd31, 1'b0, 1'b1);
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr_wins: got %b want 0", overflow); end
      // full and read at once: the write is refused
      cycle(1'b1, 5'd30, 1'b1, 1'b0);
      n_cmp++; if (count !== 3'd3)    begin n_err++; $display("FAIL ovf_full_rw: got %0d want 3", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_full_rw_flag: got %b want 1", overflow); end
      for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 1'b1, 1'b0);
      n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL ovf_empty: got %b want 1", empty); end
      cycle(1'b0, 5'd0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 5'd10, 1'b0, 1'b0);
      cycle(1'b1, 5'd11, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 5'(12 + i), 1'b1, 1'b0);
         n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count%0d: got %0d want 2", i, count); end
      end
      n_cmp++; if (out_data !== 5'd16) begin n_err++; $display("FAIL b2b_head: got %0d want 16", out_data); end
      cycle(1'b0, 5'd0, 1'b1, 1'b0);
      cycle(1'b0, 5'd0, 1'b1, 1'b0);
      // empty with read and write at once: only the write proceeds
      cycle(1'b1, 5'd5, 1'b1, 1'b0);
      n_cmp++; if (count !== 3'd1)     begin n_err++; $display("FAIL b2b_empty_rw: got %0d want 1", count); end
      n_cmp++; if (out_data !== 5'd5)  begin n_err++; $display("FAIL b2b_empty_rw_data: got %0d want 5", out_data); end
      // clr together with a write loads the sum with that word
      cycle(1'b1, 5'd3, 1'b1, 1'b1);
      n_cmp++; if (sum !== 8'd3)       begin n_err++; $display("FAIL b2b_clr_wr_sum: got %0d want 3", sum); end
      cycle(1'b0, 5'd0, 1'b1, 1'b0);
      cycle(1'b0, 5'd0, 1'b0, 1'b1);
   endtask

   task automatic test_saturation();
      logic [7:0] prev;
      prev = sum;
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, 5'd31, 1'b1, 1'b0);
         n_cmp++; if (sum < prev) begin n_err++; $display("FAIL sat_wrap%0d: got %0d want >= %0d", i, sum, prev); end
         prev = sum;
      end
      n_cmp++; if (sum !== 8'd255) begin n_err++; $display("FAIL sat_final: got %0d want 255", sum); end
      cycle(1'b0, 5'd0, 1'b1, 1'b0);
      cycle(1'b0, 5'd0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
         n_cmp++; if (count !== 3'(m_count)) begin n_err++; $display("FAIL rnd_count%0d: got %0d want %0d", i, count, m_count); end
         n_cmp++; if (sum !== 8'(m_sum))     begin n_err++; $display("FAIL rnd_sum%0d: got %0d want %0d", i, sum, m_sum); end
         n_cmp++; if (overflow !== m_ovf)    begin n_err++; $display("FAIL rnd_ovf%0d: got %b want %b", i, overflow, m_ovf); end
      end
      while (m_count != 0) cycle(1'b0, 5'd0, 1'b1, 1'b0);
      cycle(1'b0, 5'd0, 1'b0, 1'b1);
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 5'(20 + i), 1'b0, 1'b0);
      cycle(1'b1, 5'd31, 1'b0, 1'b0);
      cycle(1'b0, 5'd0, 1'b1, 1'b0);
      n_cmp++; if (count !== 3'd3)    begin n_err++; $display("FAIL mid_pre_count: got %0d want 3", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL mid_pre_ovf: got %b want 1", overflow); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL mid_count: got %0d want 0", count); end
      n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL mid_empty: got %b want 1", empty); end
      n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 5'd0)  begin n_err++; $display("FAIL mid_out_data: got %0d want 0", out_data); end
      n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL mid_ovf: got %b want 0", overflow); end
      n_cmp++; if (sum !== 8'd0)       begin n_err++; $display("FAIL mid_sum: got %0d want 0", sum); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(1'b1, 5'd17, 1'b0, 1'b0);
      n_cmp++; if (out_data !== 5'd17) begin n_err++; $display("FAIL mid_first_word: got %0d want 17", out_data); end
      n_cmp++; if (sum !== 8'd17)      begin n_err++; $display("FAIL mid_first_sum: got %0d want 17", sum); end
      cycle(1'b0, 5'd0, 1'b1, 1'b0);
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_drained: got %0d words left want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_ordering();
      test_overflow();
      test_back_to_back();
      test_saturation();
      test_random();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ma_result_fifo.md
Name: ma_result_fifo

Overview:
- Downstream stage of the multiply-accumulate block. It captures each 5-bit product word `p` that the multiply-accumulate produces into a small FIFO.
- It presents the stored words to the consumer through a valid/ready handshake.
- It keeps a saturating running total of all accepted words and a sticky overflow flag for software/debug visibility.

Parameters:
- DATA_W, 5, width of each product word (matches `p[4:0]` of the multiply-accumulate stage)
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2
- SUM_W, 8, width of the saturating running-total register

Ports:
- clk  input  1  rising-edge clock shared with the multiply-accumulate stage
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  product word on in_data is valid this cycle
- in_data  input  DATA_W  product word from the multiply-accumulate stage
- in_ready  output  1  FIFO can accept a word (equals !full)
- out_valid  output  1  out_data holds the oldest stored word
- out_data  output  DATA_W  head-of-FIFO word
- out_ready  input  1  consumer takes the word this cycle
- clr  input  1  synchronous clear of sum and overflow only
- count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: a word was offered while full
- sum  output  SUM_W  saturating total of all accepted words since reset/clr

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of clk:
  - pointers = 0, count = 0, empty = 1, full = 0
  - out_valid = 0, out_data = 0, in_ready = 1
  - overflow = 0, sum = 0
  - Storage contents need not be cleared.
- Reset mid-operation: all in-flight words are discarded. The first accepted word after rst_n deasserts is the first word read out.
- Write: `wr = in_valid & in_ready`. On a write, in_data is stored at wr_ptr and wr_ptr increments modulo DEPTH (wrap-around).
- Read: `rd = out_valid & out_ready`. On a read, rd_ptr increments modulo DEPTH.
- out_data is combinational from storage[rd_ptr]. out_valid = !empty.
- Latency: a word written at edge N is visible on out_data/out_valid after edge N. The minimum input-to-output latency is 1 cycle; there is no combinational pass-through.
- count update per edge:
  - +1 when wr & !rd
  - −1 when rd & !wr
  - unchanged when both or neither
- Simultaneous read and write:
  - When not full: both proceed and count is unchanged.
  - When full: in_ready = 0, so only the read proceeds; the write is refused even though a slot frees that cycle.
  - When empty: out_valid = 0, so only the write proceeds.
- Overflow: in_valid & full at an edge sets overflow = 1 and the word is dropped. overflow stays set until clr or reset.
- Sum:
  - On each wr, `sum <= min(sum + in_data, 2^SUM_W − 1)`, computed at SUM_W+1 bits and then saturated.
  - Refused or dropped words are not summed.
- clr (synchronous, high for one edge):
  - overflow <= 0.
  - sum <= in_data if wr in that same cycle, else 0.
  - FIFO contents, pointers and count are unaffected.
  - clr together with an overflow event: clr wins, so overflow = 0.
- full and empty are derived from count and change only at clock edges.

Decomposition:
- Shared package ma_pkg:
  - localparams MA_DATA_W = 5 and MA_SUM_W = 8, used by both the multiply-accumulate stage and this block.
  - Function sat_add(sum, data) returning the saturated total.
- One sub-module, ma_fifo_mem: DEPTH×DATA_W register array with one write port and one combinational read port.
- Pointer/count/handshake control, overflow and sum logic live in ma_result_fifo.

Test Plan:
- Reset check: hold rst_n = 0, drive in_valid = 1 → count = 0, empty = 1, in_ready = 1, out_valid = 0, sum = 0, overflow = 0. Release reset → first accepted word appears after one edge.
- Ordering: write 5'd1, 5'd6, 5'd9, 5'd25 with out_ready = 0 → full = 1, count = 4, in_ready = 0. Drain with out_ready = 1 → out_data 1, 6, 9, 25 in order, then empty = 1. sum = 41.
- Overflow: with the FIFO full, pulse in_valid with 5'd31 → overflow = 1, count stays 4, sum unchanged, and 31 is never read out. Pulse clr → overflow = 0, sum = 0, count = 4.
- Simultaneous R/W: with count = 2, hold in_valid = out_ready = 1 for 6 cycles with incrementing data → count stays 2 and out_data follows input order delayed by 2 entries. Pointers wrap past DEPTH − 1 without corruption.
- Saturation: write 5'd31 nine times, draining continuously → sum stops at 255, never wraps to a small value.
- Mid-operation reset: with count = 3 and overflow = 1, assert rst_n low between clock edges → all outputs return to reset values immediately, without waiting for clk.
